// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing and types for the RAM-backed FIFO controller and the ram16_8 benches.
// Holds the default data width, RAM depth, address width and count width,
// plus the per-cycle RAM operation type used to arbitrate the single RAM port.
package ram_fifo_ctrl_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 16;
   localparam int AW_DEF    = 4;
   // count must reach DEPTH itself, so it needs one bit more than a pointer
   localparam int CNT_W_DEF = AW_DEF + 1;

   // Only one RAM access per cycle: the single RAM port is either idle, writing or reading.
   typedef enum logic [1:0] {
      RAM_IDLE = 2'd0,
      RAM_WR   = 2'd1,
      RAM_RD   = 2'd2
   } ram_op_t;

endpackage

// File: rtl/ram_fifo_ctrl_fifo_ptr.sv
// fifo_ptr: AW-bit circular pointer that wraps from DEPTH-1 back to 0.
// Ports: clk, rst (async active-low), clr (sync zero), en (advance by one), ptr (current value).
// Latency: the new value is visible the cycle after en; clr takes priority over en.
module fifo_ptr #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [AW-1:0] ptr
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (en) begin
         // explicit wrap so DEPTH need not be a power of two
         ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller driving an external single-port RAM as a circular buffer.
// Ports: push/push_data/push_ready in, pop/pop_ready in, out_valid/out_data result,
// full/empty/count/err status, ram_addr/ram_din/ram_write/ram_read/ram_dout to the RAM.
module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_ready,
   input  logic             pop,
   output logic             pop_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             err,
   output logic [AW-1:0]    ram_addr,
   output logic [WIDTH-1:0] ram_din,
   output logic             ram_write,
   output logic             ram_read,
   input  logic [WIDTH-1:0] ram_dout
);

   localparam int          CW       = AW + 1;
   localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [WIDTH-1:0] out_last;
   logic             err_set;
   ram_op_t          op;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // Readiness is gated by rst and clr so that no RAM strobe can escape while
   // reset is held (asynchronously) or during a flush cycle.
   assign pop_ready  = rst && !clr && !empty;
   // Pop wins the single RAM port; a concurrent push simply waits.
   assign push_ready = rst && !clr && !full && !(pop && pop_ready);

   always_comb begin
      op = RAM_IDLE;
      if (pop && pop_ready) begin
         op = RAM_RD;
      end else if (push && push_ready) begin
         op = RAM_WR;
      end
   end

   assign ram_write = (op == RAM_WR);
   assign ram_read  = (op == RAM_RD);
   assign ram_addr  = (op == RAM_RD) ? rp : wp;
   assign ram_din   = push_data;

   // A push against a full FIFO is only an error when no pop is taking the
   // port; if a pop is accepted the push is merely stalled.
   assign err_set = (push && full && !(pop && pop_ready)) || (pop && empty);

   fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wp (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (ram_write),
      .ptr (wp)
   );

   fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rp (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (ram_read),
      .ptr (rp)
   );

   // Write and read are mutually exclusive, so count moves by at most one and
   // can never pass DEPTH or 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (ram_write) begin
         count <= count + 1'b1;
      end else if (ram_read) begin
         count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (clr) begin
         err <= 1'b0;
      end else if (err_set) begin
         err <= 1'b1;
      end
   end

   // out_valid marks the cycle the RAM presents the word read on the previous
   // edge; a pulse already scheduled is not cancelled by clr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= ram_read;
      end
   end

   // The RAM's read data is only meaningful during out_valid, so hold the last
   // popped word for the remaining cycles to keep out_data stable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_last <= '0;
      end else if (out_valid) begin
         out_last <= ram_dout;
      end
   end

   assign out_data = out_valid ? ram_dout : out_last;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
   import ram_fifo_ctrl_pkg::*;

   logic                 clk;
   logic                 rst;
   logic                 clr;
   logic                 push;
   logic [WIDTH_DEF-1:0] push_data;
   logic                 push_ready;
   logic                 pop;
   logic                 pop_ready;
   logic                 out_valid;
   logic [WIDTH_DEF-1:0] out_data;
   logic                 full;
   logic                 empty;
   logic [CNT_W_DEF-1:0] count;
   logic                 err;
   logic [AW_DEF-1:0]    ram_addr;
   logic [WIDTH_DEF-1:0] ram_din;
   logic                 ram_write;
   logic                 ram_read;
   logic [WIDTH_DEF-1:0] ram_dout;

   logic [WIDTH_DEF-1:0] mem [DEPTH_DEF];

   int nvec;
   int nerr;

   ram_fifo_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .push       (push),
      .push_data  (push_data),
      .push_ready (push_ready),
      .pop        (pop),
      .pop_ready  (pop_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .err        (err),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_write  (ram_write),
      .ram_read   (ram_read),
      .ram_dout   (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural single-port RAM with one-cycle read latency
   always @(posedge clk) begin
      if (ram_write) mem[ram_addr] <= ram_din;
      if (ram_read)  ram_dout <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      rst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
      #2;
      // reset state
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_err", err, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_ram_write", ram_write, 0);
      chk("rst_ram_read", ram_read, 0);
      step; step;
      @(negedge clk);
      rst = 1'b1;
      step;

      // three pushes then three pops
      push = 1'b1; push_data = 8'hF0; #1;
      chk("p1_wr", ram_write, 1); chk("p1_addr", ram_addr, 0); chk("p1_din", ram_din, 8'hF0);
      step;
      push_data = 8'hA5; #1;
      chk("p2_wr", ram_write, 1); chk("p2_addr", ram_addr, 1);
      step;
      push_data = 8'h3C; #1;
      chk("p3_wr", ram_write, 1); chk("p3_addr", ram_addr, 2);
      step;
      push = 1'b0; #1;
      chk("p_count3", count, 3);
      pop = 1'b1; #1;
      chk("q1_rd", ram_read, 1); chk("q1_addr", ram_addr, 0); chk("q1_nowr", ram_write, 0);
      step;
      chk("q1_valid", out_valid, 1); chk("q1_data", out_data, 8'hF0);
      step;
      chk("q2_valid", out_valid, 1); chk("q2_data", out_data, 8'hA5);
      step;
      pop = 1'b0; #1;
      chk("q3_valid", out_valid, 1); chk("q3_data", out_data, 8'h3C);
      chk("q_empty", empty, 1); chk("q_count0", count, 0);
      step;
      chk("q_valid_drop", out_valid, 0);
      chk("q_data_hold", out_data, 8'h3C);

      // flush pointers so the fill starts at address 0
      clr = 1'b1; step; clr = 1'b0;

      // fill to 16, then overflow
      push = 1'b1;
      for (int i = 0; i < 16; i++) begin
         push_data = 8'(i); #1;
         chk("fill_addr", ram_addr, i);
         step;
      end
      push = 1'b0; #1;
      chk("fill_full", full, 1); chk("fill_push_ready", push_ready, 0); chk("fill_count", count, 16);
      push = 1'b1; push_data = 8'hFF; #1;
      chk("ovf_nowr", ram_write, 0);
      step;
      push = 1'b0; #1;
      chk("ovf_err", err, 1); chk("ovf_count", count, 16);

      // wrap-around: pop 4, push 4 into addresses 0..3, drain
      pop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step;
         chk("wrap_pop_valid", out_valid, 1); chk("wrap_pop_data", out_data, i);
      end
      pop = 1'b0;
      push = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_data = 8'(8'hE0 + i); #1;
         chk("wrap_push_addr", ram_addr, i); chk("wrap_push_wr", ram_write, 1);
         step;
      end
      push = 1'b0; #1;
      chk("wrap_count", count, 16);
      pop = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step;
         chk("drain_valid", out_valid, 1);
         chk("drain_data", out_data, (i < 12) ? (8'h04 + i) : (8'hE0 + i - 12));
      end
      pop = 1'b0; #1;
      chk("drain_empty", empty, 1);

      // clear the sticky error
      clr = 1'b1; step; clr = 1'b0; #1;
      chk("clr_err", err, 0); chk("clr_count", count, 0);

      // simultaneous push and pop with count=2
      push = 1'b1; push_data = 8'h11; step;
      push_data = 8'h22; step;
      push_data = 8'h33; pop = 1'b1; #1;
      chk("both1_push_ready", push_ready, 0); chk("both1_rd", ram_read, 1); chk("both1_wr", ram_write, 0);
      step;
      chk("both1_data", out_data, 8'h11); chk("both1_count", count, 1); chk("both2_push_ready", push_ready, 0);
      step;
      chk("both2_data", out_data, 8'h22); chk("both2_count", count, 0); chk("both2_err", err, 0);
      chk("both3_push_ready", push_ready, 1); chk("both3_wr", ram_write, 1);
      chk("both3_rd", ram_read, 0); chk("both3_addr", ram_addr, 2);
      step;
      push = 1'b0; pop = 1'b0; #1;
      chk("both3_count", count, 1); chk("both3_err", err, 1);
      pop = 1'b1; step; pop = 1'b0; #1;
      chk("both3_data", out_data, 8'h33);

      // pop on empty, then clr with a pending push
      clr = 1'b1; step; clr = 1'b0;
      pop = 1'b1; #1;
      chk("uf_pop_ready", pop_ready, 0); chk("uf_nord", ram_read, 0);
      step;
      pop = 1'b0; #1;
      chk("uf_err", err, 1); chk("uf_valid", out_valid, 0);
      push = 1'b1; push_data = 8'h55; step;
      clr = 1'b1; #1;
      chk("clr_suppress_wr", ram_write, 0);
      step;
      clr = 1'b0; push = 1'b0; #1;
      chk("clr2_err", err, 0); chk("clr2_count", count, 0); chk("clr2_empty", empty, 1);

      // reset right after an accepted pop
      push = 1'b1; push_data = 8'h77; step;
      push_data = 8'h88; step;
      pop = 1'b1; #1;
      chk("mr_rd", ram_read, 1); chk("mr_addr", ram_addr, 0);
      step;
      rst = 1'b0; #1;
      chk("mr_valid", out_valid, 0); chk("mr_count", count, 0); chk("mr_empty", empty, 1);
      chk("mr_wr", ram_write, 0); chk("mr_rd_low", ram_read, 0); chk("mr_data", out_data, 0);
      push = 1'b0; pop = 1'b0;
      step;
      rst = 1'b1;
      step;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
